rv32m_muldiv_unit: RTL
======================

// Module: rv32m_muldiv_unit
//
// PURPOSE
//  Execute-side responder for RV32M control: consumes the op (funct3) and
//  select produced by the M-extension decoder, computes MUL/MULH/MULHSU/MULHU/
//  DIV/DIVU/REM/REMU over multiple cycles and returns a 32-bit result with a
//  done pulse. Sits in the execute stage; the pipeline stalls while busy is high.
//
// PARAMETERS
//  XLEN        32   operand/result width (only 32 supported)
//  ITER_CNT_W  5    iteration counter width (log2 XLEN)
//
// PORTS
//  CLK        in   1   clock, rising edge
//  nRST       in   1   asynchronous active-low reset
//  start      in   1   decoder select qualified by execute valid; request op
//  op         in   3   rv32m_op_t (funct3): 0 MUL,1 MULH,2 MULHSU,3 MULHU,
//                      4 DIV,5 DIVU,6 REM,7 REMU
//  rs1_data   in   32  operand A (dividend / multiplicand)
//  rs2_data   in   32  operand B (divisor / multiplier)
//  flush      in   1   kill in-flight operation (branch/exception)
//  busy       out  1   operation accepted and not yet done
//  done       out  1   one-cycle pulse; result valid this cycle
//  result     out  32  result; held stable until next accepted start
//
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, result=0, counter=0, internal regs 0.
//  - States: IDLE, RUN, FINISH.
//    IDLE: start=1 & flush=0 -> latch op, operands (sign-magnitude converted per
//      op), busy=1. Special case (div by zero, signed overflow) -> FINISH,
//      else -> RUN with counter=31.
//    RUN: one radix-2 step per cycle (shift-add for mul, restoring
//      shift-subtract for div); counter decrements; counter==0 -> FINISH.
//    FINISH: apply sign correction, register result, done=1, busy=0 -> IDLE.
//  - Latency (start edge to done high): normal 34 cycles; special cases 2.
//  - start while busy is ignored; op/operands sampled only in IDLE.
//  - flush in any state -> IDLE next edge, busy=0, no done, result unchanged.
//    flush and start in the same cycle: flush wins, start dropped.
//  - Multiply: 64-bit product; MUL returns low 32, MULH/MULHSU/MULHU high 32.
//    MULH: both signed; MULHSU: rs1 signed, rs2 unsigned; MULHU unsigned.
//    Product negated in FINISH when operand signs differ (signed cases).
//  - Divide: quotient truncates toward zero; remainder takes dividend's sign.
//  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1_data.
//  - Overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000,
//    REM -> 0x00000000.
//  - done and busy never high in the same cycle.
//
// CONFIGURATION
//  RV32M_FAST_MUL_EN defined: multiply ops use a single 33x33 signed
//    combinational multiplier; IDLE -> FINISH directly, MUL* latency 2 cycles.
//    Divide path unchanged (34 cycles).
//  Undefined: multiply uses the iterative RUN path (34 cycles); no hardware
//    multiplier inferred.
//
// TESTING
//  1. MUL rs1=7, rs2=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done at cycle 34
//     (2 with RV32M_FAST_MUL_EN).
//  2. MULH/MULHSU/MULHU rs1=rs2=0x80000000 -> 0x40000000 / 0xC0000000 /
//     0x40000000.
//  3. DIV 0x12345678 / 0 -> 0xFFFFFFFF; REMU same -> 0x12345678; done at 2.
//  4. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; done at 2.
//  5. REM 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFF; DIV -> 0xFFFFFFFD; DIVU
//     0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
//  6. Start DIVU, flush at cycle 10 -> busy=0 next cycle, no done, result
//     holds prior value; new start accepted the following cycle and completes.
//  7. Assert nRST low mid-RUN -> all outputs 0 immediately; start while busy
//     -> ignored.

Source files
------------

// File: rtl/rv32m_muldiv_unit.sv
// RV32M multiply/divide unit: radix-2 iterative shift-add / restoring divide with done pulse.
// Optional RV32M_FAST_MUL_EN: multiply ops use a single-cycle 33x33 signed multiplier.
module rv32m_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int ITER_CNT_W = 5
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t                state_reg, state_next;
  logic [ITER_CNT_W-1:0] cnt_reg, cnt_next;
  logic [XLEN-1:0]       hi_reg, hi_next;
  logic [XLEN-1:0]       lo_reg, lo_next;
  logic [XLEN-1:0]       opb_reg, opb_next;
  logic [2:0]            op_reg, op_next;
  logic                  neg_reg, neg_next;
  logic                  special_reg, special_next;
  logic [XLEN-1:0]       result_reg, result_next;
  logic                  done_reg, done_next;

  logic                  in_sa, in_sb, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]       a_mag, b_mag;
  logic [XLEN:0]         mul_sum, rem_shift;
  logic [2*XLEN-1:0]     prod_fix;
  logic [XLEN-1:0]       quo_fix, rem_fix;

`ifdef RV32M_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{XLEN{a_neg}}, rs1_data};
  assign fast_b    = {{XLEN{b_neg}}, rs2_data};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    opb_next     = opb_reg;
    op_next      = op_reg;
    neg_next     = neg_reg;
    special_next = special_reg;
    result_next  = result_reg;
    done_next    = 1'b0;

    // Signedness of each operand for the requested op: MULH, MULHSU, DIV, REM treat rs1 as signed.
    in_sa    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    in_sb    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg    = in_sa & rs1_data[XLEN-1];
    b_neg    = in_sb & rs2_data[XLEN-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
    div_zero = (rs2_data == '0);
    div_ovf  = op[2] && !op[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);

    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opb_reg} : '0);
    rem_shift = {hi_reg, lo_reg[XLEN-1]};
    prod_fix  = neg_reg ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
    quo_fix   = neg_reg ? -lo_reg : lo_reg;
    rem_fix   = neg_reg ? -hi_reg : hi_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          op_next      = op;
          special_next = 1'b0;
          cnt_next     = '1;
          hi_next      = '0;
          if (op[2]) begin
            if (div_zero) begin
              special_next = 1'b1;
              lo_next      = op[1] ? rs1_data : '1;
              state_next   = S_FINISH;
            end else if (div_ovf) begin
              special_next = 1'b1;
              lo_next      = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              state_next   = S_FINISH;
            end else begin
              lo_next    = a_mag;
              opb_next   = b_mag;
              // Remainder follows the dividend; quotient follows the sign product.
              neg_next   = op[1] ? a_neg : (a_neg ^ b_neg);
              state_next = S_RUN;
            end
          end else begin
`ifdef RV32M_FAST_MUL_EN
            {hi_next, lo_next} = fast_prod;
            neg_next           = 1'b0;
            state_next         = S_FINISH;
`else
            lo_next    = b_mag;
            opb_next   = a_mag;
            neg_next   = a_neg ^ b_neg;
            state_next = S_RUN;
`endif
          end
        end
      end
      S_RUN: begin
        if (op_reg[2]) begin
          if (rem_shift >= {1'b0, opb_reg}) begin
            hi_next = rem_shift[XLEN-1:0] - opb_reg;
            lo_next = {lo_reg[XLEN-2:0], 1'b1};
          end else begin
            hi_next = rem_shift[XLEN-1:0];
            lo_next = {lo_reg[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_next = mul_sum[XLEN:1];
          lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == '0) state_next = S_FINISH;
      end
      S_FINISH: begin
        if (special_reg) begin
          result_next = lo_reg;
        end else begin
          case (op_reg)
            3'd0:         result_next = prod_fix[XLEN-1:0];
            3'd4, 3'd5:   result_next = quo_fix;
            3'd6, 3'd7:   result_next = rem_fix;
            default:      result_next = prod_fix[2*XLEN-1:XLEN];
          endcase
        end
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // A kill abandons everything in flight, including a start in the same cycle.
    if (flush) begin
      state_next  = S_IDLE;
      done_next   = 1'b0;
      result_next = result_reg;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      opb_reg     <= '0;
      op_reg      <= '0;
      neg_reg     <= 1'b0;
      special_reg <= 1'b0;
      result_reg  <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      opb_reg     <= opb_next;
      op_reg      <= op_next;
      neg_reg     <= neg_next;
      special_reg <= special_next;
      result_reg  <= result_next;
      done_reg    <= done_next;
    end
  end

  assign busy   = (state_reg != S_IDLE);
  assign done   = done_reg;
  assign result = result_reg;

endmodule
